id_stage_pipe: RTL

//  Pipelined RV32I decode stage; successor of the single-cycle combinational decoder.

---
 rtl/id_stage_pipe_pkg.sv | 78 +++++++
 rtl/id_stage_pipe_if.sv | 55 +++++
 rtl/id_stage_pipe_decode_comb.sv | 202 ++++++++++++++++++++
 rtl/id_stage_pipe.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_pkg
// Brief    : Shared constants for the RV32I decode stage: opcodes, funct3
//            codes, ALU operation encodings, writeback/memory-size enums.
// Revision : 1.0 - initial pipelined decode release
// ============================================================================
package id_pkg;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // funct7 values that distinguish add/sub and srl/sra
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // The only two SYSTEM encodings in the base set
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  // ALU operation codes; the first group keeps the legacy decoder values
  localparam logic [4:0] ALU_ADD     = 5'b01101;
  localparam logic [4:0] ALU_SUB     = 5'b01110;
  localparam logic [4:0] ALU_XOR     = 5'b00110;
  localparam logic [4:0] ALU_SRL     = 5'b01001;
  localparam logic [4:0] ALU_OR      = 5'b00101;
  localparam logic [4:0] ALU_AND     = 5'b00100;
  localparam logic [4:0] ALU_ADDI    = 5'b01100;
  localparam logic [4:0] ALU_LD_JALR = 5'b10100;
  localparam logic [4:0] ALU_STORE   = 5'b10101;
  localparam logic [4:0] ALU_BEQ     = 5'b10001;
  localparam logic [4:0] ALU_BLT     = 5'b10010;
  // New codes for the rest of the base set
  localparam logic [4:0] ALU_SLL     = 5'b00001;
  localparam logic [4:0] ALU_SLT     = 5'b00010;
  localparam logic [4:0] ALU_SLTU    = 5'b00011;
  localparam logic [4:0] ALU_SRA     = 5'b00111;
  localparam logic [4:0] ALU_SLTI    = 5'b01000;
  localparam logic [4:0] ALU_SLTIU   = 5'b01010;
  localparam logic [4:0] ALU_XORI    = 5'b01011;
  localparam logic [4:0] ALU_ORI     = 5'b01111;
  localparam logic [4:0] ALU_ANDI    = 5'b10000;
  localparam logic [4:0] ALU_BNE     = 5'b10011;
  localparam logic [4:0] ALU_BGE     = 5'b10110;
  localparam logic [4:0] ALU_BLTU    = 5'b10111;
  localparam logic [4:0] ALU_BGEU    = 5'b11000;
  localparam logic [4:0] ALU_SLLI    = 5'b11001;
  localparam logic [4:0] ALU_SRLI    = 5'b11010;
  localparam logic [4:0] ALU_SRAI    = 5'b11011;
  localparam logic [4:0] ALU_LUI     = 5'b11100;
  localparam logic [4:0] ALU_AUIPC   = 5'b11101;
  localparam logic [4:0] ALU_JAL     = 5'b11110;
  localparam logic [4:0] ALU_NOP     = 5'b11111;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10
  } mem_size_e;

endpackage
`default_nettype wire

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Brief    : Fetch-side and execute-side handshake/bus bundle of the decode
//            stage. master = surrounding pipeline, slave = decode stage.
// Revision : 1.0 - initial pipelined decode release
// ============================================================================
interface id_stage_pipe_if #(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int ALUOP_W = 5
) ();

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        inst_i;
  logic [XLEN-1:0]    pc_i;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    pc_o;
  logic [ALUOP_W-1:0] ALUop;
  logic               ALUSrc1;
  logic               ALUSrc2;
  logic               RegWE;
  logic               MemWE;
  logic               MemRE;
  logic [1:0]         MemSize;
  logic               MemUns;
  logic [1:0]         WBSel;
  logic [2:0]         BrType;
  logic               Branch;
  logic               Jump;
  logic [XLEN-1:0]    Imm;
  logic [RF_AW-1:0]   rs1;
  logic [RF_AW-1:0]   rs2;
  logic [RF_AW-1:0]   rd;
  logic               illegal;

  modport master (
    output flush, in_valid, inst_i, pc_i, out_ready,
    input  in_ready, out_valid, pc_o, ALUop, ALUSrc1, ALUSrc2, RegWE, MemWE,
           MemRE, MemSize, MemUns, WBSel, BrType, Branch, Jump, Imm, rs1, rs2,
           rd, illegal
  );

  modport slave (
    input  flush, in_valid, inst_i, pc_i, out_ready,
    output in_ready, out_valid, pc_o, ALUop, ALUSrc1, ALUSrc2, RegWE, MemWE,
           MemRE, MemSize, MemUns, WBSel, BrType, Branch, Jump, Imm, rs1, rs2,
           rd, illegal
  );

endinterface
`default_nettype wire

// File: rtl/id_stage_pipe_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_comb
// Brief    : Pure combinational RV32I decoder: instruction word -> uop fields.
//            Illegal encodings come out with every control field cleared.
// Revision : 1.0 - initial pipelined decode release
// ============================================================================
module id_decode_comb
  import id_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RF_AW   = 5,
  parameter int ALUOP_W = 5
) (
  input  logic [31:0]        inst,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src1,
  output logic               alu_src2,
  output logic               reg_we,
  output logic               mem_we,
  output logic               mem_re,
  output logic [1:0]         mem_size,
  output logic               mem_uns,
  output logic [1:0]         wb_sel,
  output logic [2:0]         br_type,
  output logic               branch,
  output logic               jump,
  output logic [XLEN-1:0]    imm,
  output logic [RF_AW-1:0]   rs1,
  output logic [RF_AW-1:0]   rs2,
  output logic [RF_AW-1:0]   rd,
  output logic               illegal
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_funct7 = inst[31:25];

  assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
  assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign w_imm_u = {inst[31:12], 12'b0};
  assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  logic [4:0]  w_op;
  logic [31:0] w_imm32;
  logic        w_use_rs1, w_use_rs2, w_use_rd, w_wr;
  logic        w_src1, w_src2, w_we, w_re, w_uns, w_br, w_jmp, w_ill;
  mem_size_e   w_size;
  wb_sel_e     w_wb;
  logic [2:0]  w_bt;

  // Classify the instruction and pick operation, operand sources and immediate
  always_comb begin
    w_op      = ALU_NOP;
    w_imm32   = '0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_use_rd  = 1'b0;
    w_wr      = 1'b0;
    w_src1    = 1'b0;
    w_src2    = 1'b0;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_uns     = 1'b0;
    w_br      = 1'b0;
    w_jmp     = 1'b0;
    w_ill     = 1'b0;
    w_size    = MS_BYTE;
    w_wb      = WB_ALU;
    w_bt      = 3'b000;
    unique case (w_opcode)
      OP_LUI: begin
        w_op = ALU_LUI; w_src2 = 1'b1; w_imm32 = w_imm_u;
        w_use_rd = 1'b1; w_wr = 1'b1;
      end
      OP_AUIPC: begin
        w_op = ALU_AUIPC; w_src1 = 1'b1; w_src2 = 1'b1; w_imm32 = w_imm_u;
        w_use_rd = 1'b1; w_wr = 1'b1;
      end
      OP_JAL: begin
        w_op = ALU_JAL; w_src1 = 1'b1; w_src2 = 1'b1; w_imm32 = w_imm_j;
        w_use_rd = 1'b1; w_wr = 1'b1; w_wb = WB_PC4; w_jmp = 1'b1;
      end
      OP_JALR: begin
        w_op = ALU_LD_JALR; w_src2 = 1'b1; w_imm32 = w_imm_i;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1; w_wb = WB_PC4; w_jmp = 1'b1;
        w_ill = (w_funct3 != 3'b000);
      end
      OP_BRANCH: begin
        w_src1 = 1'b1; w_src2 = 1'b1; w_imm32 = w_imm_b;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_br = 1'b1; w_bt = w_funct3;
        unique case (w_funct3)
          3'b000:  w_op = ALU_BEQ;
          3'b001:  w_op = ALU_BNE;
          3'b100:  w_op = ALU_BLT;
          3'b101:  w_op = ALU_BGE;
          3'b110:  w_op = ALU_BLTU;
          3'b111:  w_op = ALU_BGEU;
          default: w_ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        w_op = ALU_LD_JALR; w_src2 = 1'b1; w_imm32 = w_imm_i; w_re = 1'b1;
        w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1; w_wb = WB_MEM;
        w_size = mem_size_e'(w_funct3[1:0]); w_uns = w_funct3[2];
        w_ill = (w_funct3 == 3'b011) || (w_funct3 == 3'b110) || (w_funct3 == 3'b111);
      end
      OP_STORE: begin
        w_op = ALU_STORE; w_src2 = 1'b1; w_imm32 = w_imm_s; w_we = 1'b1;
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
        w_size = mem_size_e'(w_funct3[1:0]);
        w_ill = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OP_IMM: begin
        w_src2 = 1'b1; w_imm32 = w_imm_i; w_use_rs1 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1;
        unique case (w_funct3)
          3'b000: w_op = ALU_ADDI;
          3'b010: w_op = ALU_SLTI;
          3'b011: w_op = ALU_SLTIU;
          3'b100: w_op = ALU_XORI;
          3'b110: w_op = ALU_ORI;
          3'b111: w_op = ALU_ANDI;
          3'b001: begin
            w_op  = ALU_SLLI;
            w_ill = (w_funct7 != F7_BASE);
          end
          default: begin
            // funct3 101: shift right, arithmetic selected by funct7
            w_op  = (w_funct7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
            w_ill = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
        endcase
      end
      OP_REG: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; w_wr = 1'b1;
        unique case ({w_funct7, w_funct3})
          {F7_BASE, 3'b000}: w_op = ALU_ADD;
          {F7_ALT,  3'b000}: w_op = ALU_SUB;
          {F7_BASE, 3'b001}: w_op = ALU_SLL;
          {F7_BASE, 3'b010}: w_op = ALU_SLT;
          {F7_BASE, 3'b011}: w_op = ALU_SLTU;
          {F7_BASE, 3'b100}: w_op = ALU_XOR;
          {F7_BASE, 3'b101}: w_op = ALU_SRL;
          {F7_ALT,  3'b101}: w_op = ALU_SRA;
          {F7_BASE, 3'b110}: w_op = ALU_OR;
          {F7_BASE, 3'b111}: w_op = ALU_AND;
          default:           w_ill = 1'b1;
        endcase
      end
      OP_FENCE:  w_ill = (w_funct3 != 3'b000);
      OP_SYSTEM: w_ill = (inst != INST_ECALL) && (inst != INST_EBREAK);
      default:   w_ill = 1'b1;
    endcase
  end

  // Drive the uop; an illegal instruction carries only its illegal flag
  always_comb begin
    illegal  = w_ill;
    alu_op   = '0;
    alu_src1 = 1'b0;
    alu_src2 = 1'b0;
    reg_we   = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    mem_size = 2'b00;
    mem_uns  = 1'b0;
    wb_sel   = 2'b00;
    br_type  = 3'b000;
    branch   = 1'b0;
    jump     = 1'b0;
    imm      = '0;
    rs1      = '0;
    rs2      = '0;
    rd       = '0;
    if (!w_ill) begin
      alu_op   = ALUOP_W'(w_op);
      alu_src1 = w_src1;
      alu_src2 = w_src2;
      reg_we   = w_wr && (inst[11:7] != 5'd0);
      mem_we   = w_we;
      mem_re   = w_re;
      mem_size = w_size;
      mem_uns  = w_uns;
      wb_sel   = w_wb;
      br_type  = w_bt;
      branch   = w_br;
      jump     = w_jmp;
      imm      = XLEN'($signed(w_imm32));
      rs1      = w_use_rs1 ? RF_AW'(inst[19:15]) : '0;
      rs2      = w_use_rs2 ? RF_AW'(inst[24:20]) : '0;
      rd       = w_use_rd  ? RF_AW'(inst[11:7])  : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Brief    : Pipelined RV32I decode stage: one registered uop slot between
//            fetch and execute, load-use interlock, flush, illegal flagging.
// Revision : 1.0 - initial pipelined decode release
// ============================================================================
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RF_AW        = 5,
  parameter int ALUOP_W      = 5,
  parameter int LU_INTERLOCK = 1
) (
  input  logic             clk,
  input  logic             rst,
  id_stage_pipe_if.slave   bus
);

  logic [ALUOP_W-1:0] w_alu_op;
  logic               w_alu_src1, w_alu_src2, w_reg_we, w_mem_we, w_mem_re;
  logic [1:0]         w_mem_size, w_wb_sel;
  logic               w_mem_uns, w_branch, w_jump, w_illegal;
  logic [2:0]         w_br_type;
  logic [XLEN-1:0]    w_imm;
  logic [RF_AW-1:0]   w_rs1, w_rs2, w_rd;

  id_decode_comb #(
    .XLEN    (XLEN),
    .RF_AW   (RF_AW),
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .inst     (bus.inst_i),
    .alu_op   (w_alu_op),
    .alu_src1 (w_alu_src1),
    .alu_src2 (w_alu_src2),
    .reg_we   (w_reg_we),
    .mem_we   (w_mem_we),
    .mem_re   (w_mem_re),
    .mem_size (w_mem_size),
    .mem_uns  (w_mem_uns),
    .wb_sel   (w_wb_sel),
    .br_type  (w_br_type),
    .branch   (w_branch),
    .jump     (w_jump),
    .imm      (w_imm),
    .rs1      (w_rs1),
    .rs2      (w_rs2),
    .rd       (w_rd),
    .illegal  (w_illegal)
  );

  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [ALUOP_W-1:0] r_alu_op;
  logic               r_alu_src1, r_alu_src2, r_reg_we, r_mem_we, r_mem_re;
  logic [1:0]         r_mem_size, r_wb_sel;
  logic               r_mem_uns, r_branch, r_jump, r_illegal;
  logic [2:0]         r_br_type;
  logic [XLEN-1:0]    r_imm;
  logic [RF_AW-1:0]   r_rs1, r_rs2, r_rd;

  logic w_hazard;
  logic w_in_ready;
  logic w_accept;

  generate
    if (LU_INTERLOCK != 0) begin : g_interlock
      // Held load targets a register the incoming instruction reads; unused
      // source fields decode to x0 and the held rd is nonzero, so they never match
      always_comb begin
        w_hazard = r_valid && r_mem_re && (r_rd != '0) && bus.in_valid &&
                   ((w_rs1 == r_rd) || (w_rs2 == r_rd));
      end
    end else begin : g_no_interlock
      assign w_hazard = 1'b0;
    end
  endgenerate

  assign w_in_ready = (!r_valid || bus.out_ready) && !w_hazard && !bus.flush;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Output slot: flush kills, accept loads, downstream acceptance empties
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_alu_op   <= '0;
      r_alu_src1 <= 1'b0;
      r_alu_src2 <= 1'b0;
      r_reg_we   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_size <= 2'b00;
      r_mem_uns  <= 1'b0;
      r_wb_sel   <= 2'b00;
      r_br_type  <= 3'b000;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_illegal  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_pc       <= bus.pc_i;
      r_alu_op   <= w_alu_op;
      r_alu_src1 <= w_alu_src1;
      r_alu_src2 <= w_alu_src2;
      r_reg_we   <= w_reg_we;
      r_mem_we   <= w_mem_we;
      r_mem_re   <= w_mem_re;
      r_mem_size <= w_mem_size;
      r_mem_uns  <= w_mem_uns;
      r_wb_sel   <= w_wb_sel;
      r_br_type  <= w_br_type;
      r_branch   <= w_branch;
      r_jump     <= w_jump;
      r_imm      <= w_imm;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_illegal  <= w_illegal;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid;
  assign bus.pc_o      = r_pc;
  assign bus.ALUop     = r_alu_op;
  assign bus.ALUSrc1   = r_alu_src1;
  assign bus.ALUSrc2   = r_alu_src2;
  assign bus.RegWE     = r_reg_we;
  assign bus.MemWE     = r_mem_we;
  assign bus.MemRE     = r_mem_re;
  assign bus.MemSize   = r_mem_size;
  assign bus.MemUns    = r_mem_uns;
  assign bus.WBSel     = r_wb_sel;
  assign bus.BrType    = r_br_type;
  assign bus.Branch    = r_branch;
  assign bus.Jump      = r_jump;
  assign bus.Imm       = r_imm;
  assign bus.rs1       = r_rs1;
  assign bus.rs2       = r_rs2;
  assign bus.rd        = r_rd;
  assign bus.illegal   = r_illegal;

endmodule
`default_nettype wire
